// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg : shared types and constants for the pipeline hazard control
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  localparam int X0             = 0;
  localparam int WAIT_CNT_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_counter.sv
// ----------------------------------------------------------------------------
// hazard_perf_counter : saturating event counter with synchronous clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_perf_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_d;
  logic [COUNT_WIDTH-1:0] count_q;

  // Clear wins over increment; all-ones is sticky until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl : per-stage stall/flush/bubble control for the 5-stage RV32I pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int FORWARDING         = 1,
  parameter int DMEM_LATENCY       = 1,
  parameter int COUNT_WIDTH        = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_address,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_address,
  input  logic                          ID_Rs1_used,
  input  logic                          ID_Rs2_used,
  input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_address,
  input  logic                          EX_Reg_wr_en,
  input  logic                          EX_Mem_rd_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0] MEM_Rd_address,
  input  logic                          MEM_Reg_wr_en,
  input  logic                          MEM_Mem_access,
  input  logic                          EX_Branch_taken,
  input  logic                          Count_clear,
  output logic                          Stall_F,
  output logic                          Stall_D,
  output logic                          Stall_E,
  output logic                          Stall_M,
  output logic                          Flush_D,
  output logic                          Flush_E,
  output logic                          Bubble_W,
  output logic [COUNT_WIDTH-1:0]        Hazard_count
);

  localparam int                         c_wait_init_i  = (DMEM_LATENCY > 1) ? (DMEM_LATENCY - 2) : 0;
  localparam logic [WAIT_CNT_WIDTH-1:0]  c_wait_init    = c_wait_init_i[WAIT_CNT_WIDTH-1:0];
  localparam logic                       c_multi_cycle  = (DMEM_LATENCY > 1);
  localparam logic                       c_forwarding   = (FORWARDING != 0);
  localparam logic [REGFILE_ADDR_WIDTH-1:0] c_x0        = REGFILE_ADDR_WIDTH'(X0);

  hazard_state_e             state_d;
  hazard_state_e             state_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;

  logic w_ex_match;
  logic w_mem_match;
  logic w_ld_use;
  logic w_ex_dep;
  logic w_mem_dep;
  logic w_data_stall;
  logic w_mem_stall;
  logic w_hazard_cycle;

  // x0 is never a real producer, and unused source fields carry junk.
  assign w_ex_match  = (EX_Rd_address != c_x0) &&
                       ((ID_Rs1_used && (ID_Rs1_address == EX_Rd_address)) ||
                        (ID_Rs2_used && (ID_Rs2_address == EX_Rd_address)));
  assign w_mem_match = (MEM_Rd_address != c_x0) &&
                       ((ID_Rs1_used && (ID_Rs1_address == MEM_Rd_address)) ||
                        (ID_Rs2_used && (ID_Rs2_address == MEM_Rd_address)));

  assign w_ld_use     = EX_Mem_rd_en  & w_ex_match;
  assign w_ex_dep     = EX_Reg_wr_en  & w_ex_match;
  assign w_mem_dep    = MEM_Reg_wr_en & w_mem_match;
  assign w_data_stall = c_forwarding ? w_ld_use : (w_ex_dep | w_mem_dep);

  // The wait counter holds the stall cycles remaining after the first one.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    w_mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_Mem_access && c_multi_cycle) begin
          w_mem_stall = 1'b1;
          state_d     = MEM_WAIT;
          wait_cnt_d  = c_wait_init;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q != '0) begin
          w_mem_stall = 1'b1;
          wait_cnt_d  = wait_cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A held memory stage freezes everything upstream, so branch/data hazards re-present later.
  always_comb begin
    Stall_F  = 1'b0;
    Stall_D  = 1'b0;
    Stall_E  = 1'b0;
    Stall_M  = 1'b0;
    Flush_D  = 1'b0;
    Flush_E  = 1'b0;
    Bubble_W = 1'b0;
    if (rst_n) begin
      if (w_mem_stall) begin
        Stall_F  = 1'b1;
        Stall_D  = 1'b1;
        Stall_E  = 1'b1;
        Stall_M  = 1'b1;
        Bubble_W = 1'b1;
      end else if (EX_Branch_taken) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (w_data_stall) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
  end

  assign w_hazard_cycle = Stall_F | Stall_D | Stall_E | Stall_M | Flush_D | Flush_E;

  hazard_perf_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_perf_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (Count_clear),
    .inc   (w_hazard_cycle),
    .count (Hazard_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W}
  localparam logic [6:0] c_v_none = 7'b0000000;
  localparam logic [6:0] c_v_data = 7'b1100010;
  localparam logic [6:0] c_v_br   = 7'b0000110;
  localparam logic [6:0] c_v_mem  = 7'b1111001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_used, id_rs2_used, ex_wr, ex_ld, mem_wr, mem_acc, br, cnt_clr;

  logic       a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_bw;
  logic       b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_bw;
  logic [3:0]  a_cnt;
  logic [31:0] b_cnt;
  logic [6:0]  a_vec, b_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_vec = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_bw};
  assign b_vec = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_bw};

  hazard_ctrl #(
    .REGFILE_ADDR_WIDTH (5),
    .FORWARDING         (1),
    .DMEM_LATENCY       (4),
    .COUNT_WIDTH        (4)
  ) u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_Rs1_address  (id_rs1),
    .ID_Rs2_address  (id_rs2),
    .ID_Rs1_used     (id_rs1_used),
    .ID_Rs2_used     (id_rs2_used),
    .EX_Rd_address   (ex_rd),
    .EX_Reg_wr_en    (ex_wr),
    .EX_Mem_rd_en    (ex_ld),
    .MEM_Rd_address  (mem_rd),
    .MEM_Reg_wr_en   (mem_wr),
    .MEM_Mem_access  (mem_acc),
    .EX_Branch_taken (br),
    .Count_clear     (cnt_clr),
    .Stall_F         (a_sf),
    .Stall_D         (a_sd),
    .Stall_E         (a_se),
    .Stall_M         (a_sm),
    .Flush_D         (a_fd),
    .Flush_E         (a_fe),
    .Bubble_W        (a_bw),
    .Hazard_count    (a_cnt)
  );

  hazard_ctrl #(
    .REGFILE_ADDR_WIDTH (5),
    .FORWARDING         (0),
    .DMEM_LATENCY       (1),
    .COUNT_WIDTH        (32)
  ) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_Rs1_address  (id_rs1),
    .ID_Rs2_address  (id_rs2),
    .ID_Rs1_used     (id_rs1_used),
    .ID_Rs2_used     (id_rs2_used),
    .EX_Rd_address   (ex_rd),
    .EX_Reg_wr_en    (ex_wr),
    .EX_Mem_rd_en    (ex_ld),
    .MEM_Rd_address  (mem_rd),
    .MEM_Reg_wr_en   (mem_wr),
    .MEM_Mem_access  (mem_acc),
    .EX_Branch_taken (br),
    .Count_clear     (cnt_clr),
    .Stall_F         (b_sf),
    .Stall_D         (b_sd),
    .Stall_E         (b_se),
    .Stall_M         (b_sm),
    .Flush_D         (b_fd),
    .Flush_E         (b_fe),
    .Bubble_W        (b_bw),
    .Hazard_count    (b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_wr = 1'b0; ex_ld = 1'b0; mem_wr = 1'b0; mem_acc = 1'b0;
    br = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic ld_use(input logic [4:0] rd, input logic used);
    ex_rd = rd; ex_wr = 1'b1; ex_ld = 1'b1;
    id_rs1 = 5'd5; id_rs1_used = used;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    mem_acc = 1'b1;
    ld_use(5'd5, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_a", 32'(a_vec), 32'(c_v_none));
    chk("rst_out_b", 32'(b_vec), 32'(c_v_none));
    chk("rst_cnt_a", 32'(a_cnt), 32'd0);
    chk("rst_cnt_b", b_cnt, 32'd0);

    @(negedge clk); rst_n = 1'b1; clr();

    // load-use Rd=5 vs Rs1=5
    @(negedge clk); clr(); ld_use(5'd5, 1'b1); #2;
    chk("lduse_a", 32'(a_vec), 32'(c_v_data));
    chk("lduse_b", 32'(b_vec), 32'(c_v_data));
    @(negedge clk); clr(); ld_use(5'd0, 1'b1); id_rs1 = 5'd0; #2;
    chk("lduse_x0_a", 32'(a_vec), 32'(c_v_none));
    chk("lduse_x0_b", 32'(b_vec), 32'(c_v_none));
    @(negedge clk); clr(); ld_use(5'd5, 1'b0); #2;
    chk("lduse_unused_a", 32'(a_vec), 32'(c_v_none));
    chk("lduse_unused_b", 32'(b_vec), 32'(c_v_none));

    // MEM dependency Rd=7 vs Rs2=7
    @(negedge clk); clr(); mem_wr = 1'b1; mem_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1; #2;
    chk("memdep_fwd_a", 32'(a_vec), 32'(c_v_none));
    chk("memdep_nofwd_b", 32'(b_vec), 32'(c_v_data));

    // load-use together with taken branch
    @(negedge clk); clr(); ld_use(5'd5, 1'b1); br = 1'b1; #2;
    chk("br_lduse_a", 32'(a_vec), 32'(c_v_br));
    chk("br_lduse_b", 32'(b_vec), 32'(c_v_br));

    // EX ALU dependency Rd=3 vs Rs2=3
    @(negedge clk); clr(); ex_wr = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1; #2;
    chk("exdep_fwd_a", 32'(a_vec), 32'(c_v_none));
    chk("exdep_nofwd_b", 32'(b_vec), 32'(c_v_data));

    // memory wait: three stall cycles then release, branch ignored mid-wait
    @(negedge clk); clr(); #2;
    chk("cnt1_a", 32'(a_cnt), 32'd2);
    chk("cnt1_b", b_cnt, 32'd4);
    mem_acc = 1'b1; #1;
    chk("mem_c1_a", 32'(a_vec), 32'(c_v_mem));
    chk("mem_lat1_b", 32'(b_vec), 32'(c_v_none));
    @(negedge clk); clr(); mem_acc = 1'b1; br = 1'b1; #2;
    chk("mem_c2_br_a", 32'(a_vec), 32'(c_v_mem));
    chk("br_b", 32'(b_vec), 32'(c_v_br));
    @(negedge clk); clr(); mem_acc = 1'b1; #2;
    chk("mem_c3_a", 32'(a_vec), 32'(c_v_mem));
    @(negedge clk); clr(); mem_acc = 1'b1; #2;
    chk("mem_done_a", 32'(a_vec), 32'(c_v_none));
    @(negedge clk); clr(); #2;
    chk("mem_idle_a", 32'(a_vec), 32'(c_v_none));
    chk("cnt2_a", 32'(a_cnt), 32'd5);
    chk("cnt2_b", b_cnt, 32'd5);

    // reset on the second MEM_WAIT cycle
    @(negedge clk); clr(); mem_acc = 1'b1; #2;
    chk("mem2_c1_a", 32'(a_vec), 32'(c_v_mem));
    @(negedge clk); clr(); mem_acc = 1'b1; #2;
    chk("mem2_c2_a", 32'(a_vec), 32'(c_v_mem));
    @(negedge clk); clr(); mem_acc = 1'b1; rst_n = 1'b0; #2;
    chk("midrst_out_a", 32'(a_vec), 32'(c_v_none));
    chk("midrst_cnt_a", 32'(a_cnt), 32'd0);
    chk("midrst_cnt_b", b_cnt, 32'd0);
    @(negedge clk); clr(); rst_n = 1'b1; #2;
    chk("postrst_a", 32'(a_vec), 32'(c_v_none));

    // saturation with 20 hazard cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 14) chk("sat_pre_a", 32'(a_cnt), 32'd14);
      clr(); ld_use(5'd5, 1'b1);
    end
    @(negedge clk); clr(); #2;
    chk("sat_a", 32'(a_cnt), 32'd15);
    chk("sat_b", b_cnt, 32'd20);

    // clear wins over a simultaneous hazard
    ld_use(5'd5, 1'b1); cnt_clr = 1'b1; #1;
    chk("clr_hz_a", 32'(a_vec), 32'(c_v_data));
    @(negedge clk); clr(); #2;
    chk("clr_a", 32'(a_cnt), 32'd0);
    chk("clr_b", b_cnt, 32'd0);
    ld_use(5'd5, 1'b1);
    @(negedge clk); clr(); #2;
    chk("inc_after_clr_a", 32'(a_cnt), 32'd1);
    chk("inc_after_clr_b", b_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
